// File: rtl/quant_frame_sequencer_if.sv
// Stream bundle between the frame sequencer, its sample source, the shared
// quantizer and the level-LUT/encoder sink.
interface quant_frame_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int LVL_W  = 4,
    parameter int IDX_W  = 10
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              sample_ready;
    logic              q_en;
    logic [DATA_W-1:0] q_value;
    logic [LVL_W-1:0]  q_level;
    logic              lvl_valid;
    logic              lvl_ready;
    logic [LVL_W-1:0]  lvl_level;
    logic [IDX_W-1:0]  lvl_index;
    logic              lvl_last;

    modport master (
        output sample_valid, sample_data, q_level, lvl_ready,
        input  sample_ready, q_en, q_value, lvl_valid, lvl_level, lvl_index, lvl_last
    );
    modport slave (
        input  sample_valid, sample_data, q_level, lvl_ready,
        output sample_ready, q_en, q_value, lvl_valid, lvl_level, lvl_index, lvl_last
    );
endinterface

// File: rtl/quant_frame_sequencer.sv
// Walks one feature frame through the shared combinational quantizer and
// registers each returned level with its feature index for the encoder stage.
module quant_frame_sequencer #(
    parameter int N_FEATURES = 617,
    parameter int DATA_W     = 16,
    parameter int LVL_W      = 4,
    parameter int IDX_W      = $clog2(N_FEATURES)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start,
    input  logic                   abort,
    quant_frame_sequencer_if.slave bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEATURES - 1);
    localparam logic [LVL_W-1:0] MAX_LVL  = LVL_W'(10);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   counter_q, counter_d;
    logic               lvl_valid_q, lvl_valid_d;
    logic [LVL_W-1:0]   lvl_level_q, lvl_level_d;
    logic [IDX_W-1:0]   lvl_index_q, lvl_index_d;
    logic               err_q, err_d;
    logic               accept, handshake, lvl_last;

    // One output register: a new sample may enter only if the slot empties this cycle.
    assign bus.sample_ready = (state_q == RUN) && (!lvl_valid_q || bus.lvl_ready);
    assign accept           = bus.sample_valid && bus.sample_ready;
    assign handshake        = lvl_valid_q && bus.lvl_ready;
    assign lvl_last         = (lvl_index_q == LAST_IDX);

    assign bus.q_en      = accept;
    assign bus.q_value   = bus.sample_data;
    assign bus.lvl_valid = lvl_valid_q;
    assign bus.lvl_level = lvl_level_q;
    assign bus.lvl_index = lvl_index_q;
    assign bus.lvl_last  = lvl_last;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign err  = err_q;

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        lvl_valid_d = lvl_valid_q;
        lvl_level_d = lvl_level_q;
        lvl_index_d = lvl_index_q;
        err_d       = err_q;
        if (abort) begin
            state_d     = IDLE;
            lvl_valid_d = 1'b0;
            counter_d   = '0;
        end else begin
            if (accept) begin
                lvl_level_d = bus.q_level;
                lvl_index_d = counter_q;
                lvl_valid_d = 1'b1;
                // Holds at the last index; the FSM stops accepting there.
                if (counter_q != LAST_IDX) counter_d = counter_q + 1'b1;
                if (bus.q_level == '0 || bus.q_level > MAX_LVL) err_d = 1'b1;
            end else if (handshake) begin
                lvl_valid_d = 1'b0;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_d   = RUN;
                    counter_d = '0;
                    err_d     = 1'b0;
                end
                RUN:     if (accept && counter_q == LAST_IDX) state_d = DRAIN;
                DRAIN:   if (handshake && lvl_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            lvl_valid_q <= 1'b0;
            lvl_level_q <= '0;
            lvl_index_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            lvl_valid_q <= lvl_valid_d;
            lvl_level_q <= lvl_level_d;
            lvl_index_q <= lvl_index_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_quant_frame_sequencer.sv
// Randomized and directed frames against a queue-based model of the frame
// sequencer, with a behavioural quantizer closing the combinational loop.
module tb_quant_frame_sequencer;
    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int LVL_W  = 4;
    localparam int IDX_W  = $clog2(N);

    typedef struct { int lvl; int idx; } ent_t;

    logic clk = 1'b0;
    logic nrst, start, abort;
    logic busy, done, err;
    bit   fq;
    logic [3:0] fv;

    int n_chk = 0, n_err = 0;
    ent_t q[$];
    bit   m_busy, m_done, m_err;
    int   m_acc;
    int   busy_seen, done_seen, hs_seen;

    quant_frame_sequencer_if #(.DATA_W(DATA_W), .LVL_W(LVL_W), .IDX_W(IDX_W)) bus ();

    quant_frame_sequencer #(.N_FEATURES(N), .DATA_W(DATA_W), .LVL_W(LVL_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // 2048-wide bins, level 6 just below zero, clamped to 1..10.
    function automatic int quant(input logic signed [15:0] v);
        int l;
        l = 5 - int'(v >>> 11);
        if (l < 1) l = 1;
        if (l > 10) l = 10;
        return l;
    endfunction

    assign bus.q_level = fq ? fv : 4'(quant(bus.q_value));

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_busy = 0; m_done = 0; m_err = 0; m_acc = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sample_ready"}, bus.sample_ready, 0);
        chk({tag, "_q_en"}, bus.q_en, 0);
        chk({tag, "_lvl_valid"}, bus.lvl_valid, 0);
        chk({tag, "_lvl_last"}, bus.lvl_last, 0);
        chk({tag, "_lvl_level"}, bus.lvl_level, 0);
        chk({tag, "_lvl_index"}, bus.lvl_index, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // One clock: drive just after the edge, check at negedge, advance model.
    task automatic step(input bit st, input bit ab, input bit sv, input logic [15:0] sd,
                        input bit lr, input bit fqi, input logic [3:0] fvi);
        bit er, hs, acc, nd;
        ent_t e;
        start = st; abort = ab; bus.sample_valid = sv; bus.sample_data = sd;
        bus.lvl_ready = lr; fq = fqi; fv = fvi;
        @(negedge clk);
        er = m_busy && (m_acc < N) && (q.size() == 0 || lr);
        chk("sample_ready", bus.sample_ready, int'(er));
        chk("q_en", bus.q_en, int'(sv && er));
        chk("q_value", bus.q_value, sd);
        chk("lvl_valid", bus.lvl_valid, int'(q.size() != 0));
        chk("busy", busy, int'(m_busy));
        chk("done", done, int'(m_done));
        chk("err", err, int'(m_err));
        if (q.size() != 0) begin
            chk("lvl_level", bus.lvl_level, q[0].lvl);
            chk("lvl_index", bus.lvl_index, q[0].idx);
            chk("lvl_last", bus.lvl_last, int'(q[0].idx == N - 1));
        end
        busy_seen += int'(busy);
        done_seen += int'(done);
        hs = (q.size() != 0) && lr;
        acc = sv && er;
        if (ab) begin
            q.delete(); m_busy = 0; m_acc = 0; m_done = 0;
        end else begin
            nd = 0;
            if (hs) begin
                e = q.pop_front();
                hs_seen++;
                if (e.idx == N - 1) nd = 1;
            end
            if (acc) begin
                e.lvl = fqi ? int'(fvi) : quant(sd);
                e.idx = m_acc;
                q.push_back(e);
                if (e.lvl == 0 || e.lvl > 10) m_err = 1;
                m_acc++;
            end
            if (m_done) m_busy = 0;
            else if (!m_busy && st) begin
                m_busy = 1; m_acc = 0; m_err = 0;
            end
            m_done = nd;
        end
        @(posedge clk); #1;
    endtask

    // mode: 0 clean, 1 back-pressure on idx1, 2 start at idx2, 3 abort at idx2,
    //       4 level 0 on idx1, 5 random, 6 partial frame with bad idx0
    task automatic frame(input int mode);
        logic [15:0] dir [4];
        int cyc, hold;
        bit st, ab, sv, lr, f, aborted;
        logic [3:0] v;
        logic [15:0] sd;
        dir[0] = 16'sd9000; dir[1] = 16'sd5000; dir[2] = -16'sd1; dir[3] = -16'sd9000;
        cyc = 0; hold = 0; aborted = 0;
        busy_seen = 0; done_seen = 0; hs_seen = 0;
        step(1, 0, 0, 16'h0, 1, 0, 4'h0);
        while (m_busy && cyc < 300) begin
            if (mode == 6 && m_acc == 3) break;
            st = 0; ab = 0; sv = 1; lr = 1; f = 0; v = 4'h0;
            sd = (mode == 5) ? 16'($urandom) : dir[m_acc % 4];
            case (mode)
                1: if (q.size() != 0 && q[0].idx == 1 && hold < 3) begin lr = 0; hold++; end
                2: st = (m_acc == 2);
                3: if (q.size() != 0 && q[0].idx == 2 && !aborted) begin ab = 1; aborted = 1; end
                4: f = (m_acc == 1);
                5: begin
                    sv = ($urandom_range(0, 3) != 0);
                    lr = ($urandom_range(0, 2) != 0);
                    st = ($urandom_range(0, 15) == 0);
                    ab = ($urandom_range(0, 63) == 0);
                    f  = ($urandom_range(0, 15) == 0);
                    v  = 4'($urandom_range(0, 15));
                end
                6: begin f = (m_acc == 0); v = 4'd12; end
                default: ;
            endcase
            step(st, ab, sv, sd, lr, f, v);
            cyc++;
        end
        if (cyc >= 300) chk("frame_timeout", cyc, 0);
        if (mode != 6) repeat (3) step(0, 0, 0, 16'h0, 1, 0, 4'h0);
    endtask

    initial begin
        nrst = 0; start = 0; abort = 0; fq = 0; fv = 0;
        bus.sample_valid = 0; bus.sample_data = 0; bus.lvl_ready = 0;
        m_reset();
        #12;
        check_zero("reset");
        @(posedge clk); #1 nrst = 1;

        frame(0);
        chk("t2_busy_cycles", busy_seen, 6);
        chk("t2_done_pulses", done_seen, 1);
        chk("t2_levels", hs_seen, 4);

        frame(1);
        chk("t3_done_pulses", done_seen, 1);
        chk("t3_levels", hs_seen, 4);

        frame(2);
        chk("t4_done_pulses", done_seen, 1);
        chk("t4_levels", hs_seen, 4);

        frame(3);
        chk("t5_done_pulses", done_seen, 0);
        frame(0);
        chk("t5_restart_levels", hs_seen, 4);

        frame(4);
        chk("t6_err_sticky", err, 1);
        frame(0);
        chk("t6_err_cleared", err, 0);

        frame(6);
        chk("t1_err_before_reset", err, 1);
        #2 nrst = 0;
        #1 check_zero("async_reset");
        m_reset();
        @(posedge clk); #1 nrst = 1;
        frame(0);
        chk("t1_after_reset_levels", hs_seen, 4);

        repeat (25) frame(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
